jdequant_rle: RTL

- Upstream neighbour of the inverse-zigzag page.
- Expands run-length coded coefficient tokens into a dense stream of 64 coefficients per 8x8 block, in zigzag order.
- Multiplies each nonzero amplitude by the quantizer entry for its zigzag index.
- Drives the ruS stream that the inverse-zigzag stage consumes.

---
 rtl/jdequant_rle.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/jdequant_rle.sv
// Expands run-length coefficient tokens into 64 dequantized coefficients per block, in zigzag order.
// One-entry output register: 1-cycle accept-to-output latency, full rate when downstream is ready.
module jdequant_rle #(
  parameter int AW = 12,
  parameter int QW = 8,
  parameter int DW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [15:0]   rlS_d,
  input  logic          rlS_e,
  input  logic          rlS_v,
  output logic          rlS_b,
  input  logic          q_we,
  input  logic [5:0]    q_addr,
  input  logic [QW-1:0] q_data,
  output logic [DW-1:0] ruS_d,
  output logic          ruS_e,
  output logic          ruS_v,
  input  logic          ruS_b,
  output logic          blk_done,
  output logic          err
);

  localparam int PW = AW + QW + 1;

  localparam logic [2:0] ST_ACCEPT  = 3'd0;
  localparam logic [2:0] ST_ZFILL   = 3'd1;
  localparam logic [2:0] ST_EMIT    = 3'd2;
  localparam logic [2:0] ST_EOBFILL = 3'd3;
  localparam logic [2:0] ST_EOS     = 3'd4;

  localparam logic signed [PW-1:0] SAT_HI = {{(PW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_LO = {{(PW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic [2:0]    state_q, state_d;
  logic [5:0]    k_q, k_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] amp_q, amp_d;
  logic          amp_vld_q, amp_vld_d;
  logic          pend_eos_q, pend_eos_d;
  logic          eos_ld_q, eos_ld_d;
  logic          err_q, err_d;

  logic [DW-1:0] out_d_q;
  logic          out_e_q;
  logic          out_v_q;
  logic          out_last_q;
  logic          blk_done_q;

  logic [QW-1:0] qtab_q [64];

  logic          can_load;
  logic          out_xfer;
  logic          acc_ok;
  logic          tok_acc;
  logic [3:0]    tok_run;
  logic [AW-1:0] tok_amp;

  logic          ld;
  logic          ld_e;
  logic          ld_zero;
  logic [AW-1:0] amp_sel;
  logic signed [PW-1:0] amp_x;
  logic signed [PW-1:0] q_x;
  logic signed [PW-1:0] prod;
  logic [DW-1:0] coef;

  assign out_xfer = out_v_q & ~ruS_b;
  assign can_load = ~out_v_q | ~ruS_b;
  assign acc_ok   = (state_q == ST_ACCEPT) & can_load;
  assign rlS_b    = reset | ~acc_ok;
  assign tok_acc  = rlS_v & acc_ok;
  assign tok_run  = rlS_d[15:12];
  assign tok_amp  = rlS_d[AW-1:0];

  assign ruS_d    = out_d_q;
  assign ruS_e    = out_e_q;
  assign ruS_v    = out_v_q;
  assign blk_done = blk_done_q;
  assign err      = err_q;

  // Signed amplitude times unsigned table entry, clamped to the output range.
  always_comb begin
    amp_x = {{(PW-AW){amp_sel[AW-1]}}, amp_sel};
    q_x   = {{(PW-QW){1'b0}}, qtab_q[k_q]};
    prod  = amp_x * q_x;
    if (prod > SAT_HI) begin
      coef = SAT_HI[DW-1:0];
    end else if (prod < SAT_LO) begin
      coef = SAT_LO[DW-1:0];
    end else begin
      coef = prod[DW-1:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    cnt_d      = cnt_q;
    amp_d      = amp_q;
    amp_vld_d  = amp_vld_q;
    pend_eos_d = pend_eos_q;
    eos_ld_d   = eos_ld_q;
    err_d      = err_q;
    ld         = 1'b0;
    ld_e       = 1'b0;
    ld_zero    = 1'b1;
    amp_sel    = amp_q;

    case (state_q)
      ST_ACCEPT: begin
        amp_sel = tok_amp;
        if (tok_acc) begin
          if (rlS_e) begin
            if (k_q == 6'd0) begin
              ld       = 1'b1;
              ld_e     = 1'b1;
              eos_ld_d = 1'b1;
              state_d  = ST_EOS;
            end else begin
              pend_eos_d = 1'b1;
              state_d    = ST_EOBFILL;
            end
          end else if (tok_amp == '0) begin
            if (tok_run == 4'd0) begin
              if (k_q != 6'd0) begin
                ld = 1'b1;
                if (k_q != 6'd63) state_d = ST_EOBFILL;
              end
            end else begin
              ld        = 1'b1;
              amp_vld_d = 1'b0;
              if (k_q == 6'd63) begin
                err_d = 1'b1;
              end else begin
                cnt_d   = tok_run;
                state_d = ST_ZFILL;
              end
            end
          end else if (tok_run == 4'd0) begin
            ld      = 1'b1;
            ld_zero = 1'b0;
          end else begin
            ld = 1'b1;
            // A run starting at k=63 cannot place its amplitude in this block.
            if (k_q == 6'd63) begin
              err_d     = 1'b1;
              amp_vld_d = 1'b0;
            end else begin
              amp_d     = tok_amp;
              amp_vld_d = 1'b1;
              cnt_d     = tok_run - 4'd1;
              state_d   = (tok_run == 4'd1) ? ST_EMIT : ST_ZFILL;
            end
          end
        end
      end

      ST_ZFILL: begin
        if (can_load) begin
          ld    = 1'b1;
          cnt_d = cnt_q - 4'd1;
          if (k_q == 6'd63) begin
            if ((cnt_q != 4'd1) || amp_vld_q) err_d = 1'b1;
            amp_vld_d = 1'b0;
            state_d   = ST_ACCEPT;
          end else if (cnt_q == 4'd1) begin
            state_d = amp_vld_q ? ST_EMIT : ST_ACCEPT;
          end
        end
      end

      ST_EMIT: begin
        if (can_load) begin
          ld        = 1'b1;
          ld_zero   = 1'b0;
          amp_vld_d = 1'b0;
          state_d   = ST_ACCEPT;
        end
      end

      ST_EOBFILL: begin
        if (can_load) begin
          ld = 1'b1;
          if (k_q == 6'd63) begin
            state_d    = pend_eos_q ? ST_EOS : ST_ACCEPT;
            pend_eos_d = 1'b0;
            eos_ld_d   = 1'b0;
          end
        end
      end

      ST_EOS: begin
        if (!eos_ld_q) begin
          if (can_load) begin
            ld       = 1'b1;
            ld_e     = 1'b1;
            eos_ld_d = 1'b1;
          end
        end else if (out_xfer) begin
          eos_ld_d = 1'b0;
          state_d  = ST_ACCEPT;
        end
      end

      default: state_d = ST_ACCEPT;
    endcase

    if (ld && !ld_e) k_d = k_q + 6'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_ACCEPT;
      k_q        <= '0;
      cnt_q      <= '0;
      amp_q      <= '0;
      amp_vld_q  <= 1'b0;
      pend_eos_q <= 1'b0;
      eos_ld_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      cnt_q      <= cnt_d;
      amp_q      <= amp_d;
      amp_vld_q  <= amp_vld_d;
      pend_eos_q <= pend_eos_d;
      eos_ld_q   <= eos_ld_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_d_q    <= '0;
      out_e_q    <= 1'b0;
      out_v_q    <= 1'b0;
      out_last_q <= 1'b0;
      blk_done_q <= 1'b0;
    end else begin
      blk_done_q <= out_xfer & out_last_q;
      if (ld) begin
        out_d_q    <= ld_zero ? '0 : coef;
        out_e_q    <= ld_e;
        out_v_q    <= 1'b1;
        out_last_q <= ~ld_e & (k_q == 6'd63);
      end else if (out_xfer) begin
        out_e_q    <= 1'b0;
        out_v_q    <= 1'b0;
        out_last_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) qtab_q[i] <= QW'(1);
    end else if (q_we) begin
      qtab_q[q_addr] <= q_data;
    end
  end

endmodule
